// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Brief    : Condition/op select encodings for the micro-sequencer and a
//             helper that evaluates a branch condition against the flags.
//  Revision : 1.0  initial release
// ============================================================================
package seq_pkg;

    localparam int DSEL_W = 4;

    localparam logic [DSEL_W-1:0] DSEL_NEVER  = 4'd0;
    localparam logic [DSEL_W-1:0] DSEL_ALWAYS = 4'd2;
    localparam logic [DSEL_W-1:0] DSEL_C      = 4'd3;
    localparam logic [DSEL_W-1:0] DSEL_NC     = 4'd4;
    localparam logic [DSEL_W-1:0] DSEL_Z      = 4'd5;
    localparam logic [DSEL_W-1:0] DSEL_NZ     = 4'd6;
    localparam logic [DSEL_W-1:0] DSEL_V      = 4'd7;
    localparam logic [DSEL_W-1:0] DSEL_NV     = 4'd8;
    localparam logic [DSEL_W-1:0] DSEL_S      = 4'd9;
    localparam logic [DSEL_W-1:0] DSEL_NS     = 4'd10;
    localparam logic [DSEL_W-1:0] DSEL_CALL   = 4'd11;
    localparam logic [DSEL_W-1:0] DSEL_RET    = 4'd12;

    // First reserved encoding; everything from here up is illegal.
    localparam logic [DSEL_W-1:0] DSEL_RSVD_LO = 4'd13;

    // True when a conditional-branch select is satisfied by the flags.
    // NEVER, CALL, RET and reserved codes all report false here.
    function automatic logic cond_eval(
        input logic [DSEL_W-1:0] sel,
        input logic              z,
        input logic              c,
        input logic              v,
        input logic              s
    );
        logic res;
        res = 1'b0;
        case (sel)
            DSEL_ALWAYS: res = 1'b1;
            DSEL_C:      res = c;
            DSEL_NC:     res = ~c;
            DSEL_Z:      res = z;
            DSEL_NZ:     res = ~z;
            DSEL_V:      res = v;
            DSEL_NV:     res = ~v;
            DSEL_S:      res = s;
            DSEL_NS:     res = ~s;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ret_stack
//  Brief    : Small return-address LIFO. Push while full and pop while empty
//             are ignored; the caller is responsible for flagging them.
//  Revision : 1.0  initial release
// ============================================================================
module ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] top
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_mem [DEPTH];

    assign full  = (r_sp == SPW'(DEPTH));
    assign empty = (r_sp == '0);

    // Stack pointer: counts valid entries; cleared by reset to discard the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SPW'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    // Entry storage: write the slot just above the current top on push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && (r_sp == SPW'(i))) begin
                r_mem[i] <= din;
            end
        end
    end

    // Top-of-stack read mux; returns entry 0 when empty (value unused then).
    always_comb begin
        top = r_mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (r_sp == SPW'(i + 1)) begin
                top = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Brief    : Micro-PC sequencer with registered Z/C/V/S flags, conditional
//             branch, call/return via a return-address LIFO, and sticky
//             error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int            AW         = 8,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DSEL_W-1:0] dsel,
    input  logic [AW-1:0]     target,
    input  logic              flag_we,
    input  logic              zin,
    input  logic              cin,
    input  logic              vin,
    input  logic              sin,
    output logic [AW-1:0]     upc,
    output logic              taken,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              illegal_sel
);

    logic r_z, r_c, r_v, r_s;
    logic [AW-1:0] r_upc;
    logic          r_taken;
    logic          r_ovf, r_unf, r_ill;

    logic [AW-1:0] w_upc_inc;
    logic [AW-1:0] w_upc_nxt;
    logic          w_taken_nxt;
    logic          w_push, w_pop;
    logic          w_full, w_empty;
    logic [AW-1:0] w_top;
    logic          w_ovf_set, w_unf_set, w_ill_set;

    // Sequential address wraps naturally at AW bits; also used as return address.
    assign w_upc_inc = r_upc + AW'(1);

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_upc_inc),
        .full  (w_full),
        .empty (w_empty),
        .top   (w_top)
    );

    // Flag register: loads independently of en; conditions see only stored values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
            r_s <= 1'b0;
        end else if (flag_we) begin
            r_z <= zin;
            r_c <= cin;
            r_v <= vin;
            r_s <= sin;
        end
    end

    // Next-address selection, stack control and error detection for one advance.
    always_comb begin
        w_upc_nxt   = w_upc_inc;
        w_taken_nxt = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_ill_set   = 1'b0;
        if (en) begin
            case (dsel)
                DSEL_CALL: begin
                    w_push      = ~w_full;
                    w_ovf_set   = w_full;
                    w_upc_nxt   = target;
                    w_taken_nxt = 1'b1;
                end
                DSEL_RET: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_upc_nxt   = w_top;
                        w_taken_nxt = 1'b1;
                    end else begin
                        w_unf_set   = 1'b1;
                    end
                end
                default: begin
                    w_ill_set = (dsel >= DSEL_RSVD_LO);
                    if (cond_eval(dsel, r_z, r_c, r_v, r_s)) begin
                        w_upc_nxt   = target;
                        w_taken_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    // Micro-PC and taken indicator advance only on en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc   <= RESET_ADDR;
            r_taken <= 1'b0;
        end else if (en) begin
            r_upc   <= w_upc_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_ill <= 1'b0;
        end else begin
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
            if (w_ill_set) r_ill <= 1'b1;
        end
    end

    assign upc         = r_upc;
    assign taken       = r_taken;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;
    assign illegal_sel = r_ill;

endmodule
`default_nettype wire
